// File: rtl/oled_mode_scheduler.sv
// Command stage in front of OLED_interface: queues mode requests and hands them
// over with a START held until the interface drops ready, then waits for ready to return.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a queued request and a ready interface; pops head
// S_CHECK | turn-on ordering check on the popped mode, raises START if ok
// S_ISSUE | START held high until the interface drops ready (ack) or timeout
// S_DONE  | START low, waiting for ready to return high or timeout
module oled_mode_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_TIMEOUT  = 200,
    parameter int DONE_TIMEOUT = 12000000
) (
    input  logic                            i_CLK,
    input  logic                            i_RST,
    input  logic                            i_REQ_VALID,
    input  logic [1:0]                      i_REQ_MODE,
    output logic                            o_REQ_READY,
    input  logic                            i_ERR_CLR,
    input  logic                            i_OLED_READY,
    output logic [1:0]                      o_MODE,
    output logic                            o_START,
    output logic                            o_BUSY,
    output logic                            o_DISPLAY_ON,
    output logic                            o_ERR_ORDER,
    output logic                            o_ERR_TIMEOUT,
    output logic [$clog2(FIFO_DEPTH):0]     o_FIFO_COUNT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] DONE_LAST = 32'(DONE_TIMEOUT - 1);
    localparam logic [1:0]  MODE_TURNON = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;

    logic          rdy_meta;
    logic          rdy;

    logic [1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          req_ready_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [1:0]    mode_q, mode_nxt;
    logic [1:0]    out_mode_q, out_mode_nxt;
    logic          start_q, start_nxt;
    logic [31:0]   timer, timer_nxt;
    logic          disp_on_q, disp_on_nxt;
    logic          err_order_q;
    logic          err_timeout_q;
    logic          err_order_ev;
    logic          err_timeout_ev;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = i_REQ_VALID && req_ready_q && !fifo_full;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Ready synchroniser: the interface runs its handshake off a divided clock.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rdy_meta <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            rdy_meta <= i_OLED_READY;
            rdy      <= rdy_meta;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_REQ_MODE;
        end
    end

    // req_ready tracks the post-update count so a full FIFO never sees an accepted push.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count_nxt;
            req_ready_q <= (count_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode_q;
        out_mode_nxt   = out_mode_q;
        start_nxt      = start_q;
        timer_nxt      = timer;
        disp_on_nxt    = disp_on_q;
        err_order_ev   = 1'b0;
        err_timeout_ev = 1'b0;
        pop            = 1'b0;

        case (state)
            S_IDLE: begin
                start_nxt = 1'b0;
                if (!fifo_empty && rdy) begin
                    pop       = 1'b1;
                    mode_nxt  = fifo_mem[rd_ptr];
                    state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mode_q != MODE_TURNON && !disp_on_q) begin
                    err_order_ev = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    out_mode_nxt = mode_q;
                    start_nxt    = 1'b1;
                    timer_nxt    = '0;
                    state_nxt    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                start_nxt = 1'b1;
                if (!rdy) begin
                    start_nxt = 1'b0;
                    timer_nxt = '0;
                    state_nxt = S_DONE;
                end else if (timer == ACK_LAST) begin
                    start_nxt      = 1'b0;
                    err_timeout_ev = 1'b1;
                    state_nxt      = S_IDLE;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end

            S_DONE: begin
                start_nxt = 1'b0;
                if (rdy) begin
                    if (mode_q == MODE_TURNON) begin
                        disp_on_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end else if (timer == DONE_LAST) begin
                    err_timeout_ev = 1'b1;
                    disp_on_nxt    = 1'b0;
                    state_nxt      = S_IDLE;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end

            default: begin
                start_nxt = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A fresh error event outranks a clear arriving in the same cycle.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state         <= S_IDLE;
            mode_q        <= 2'b00;
            out_mode_q    <= 2'b00;
            start_q       <= 1'b0;
            timer         <= '0;
            disp_on_q     <= 1'b0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            mode_q        <= mode_nxt;
            out_mode_q    <= out_mode_nxt;
            start_q       <= start_nxt;
            timer         <= timer_nxt;
            disp_on_q     <= disp_on_nxt;
            err_order_q   <= (err_order_q && !i_ERR_CLR) || err_order_ev;
            err_timeout_q <= (err_timeout_q && !i_ERR_CLR) || err_timeout_ev;
        end
    end

    assign o_REQ_READY   = req_ready_q;
    assign o_MODE        = out_mode_q;
    assign o_START       = start_q;
    assign o_BUSY        = (state != S_IDLE) || !fifo_empty;
    assign o_DISPLAY_ON  = disp_on_q;
    assign o_ERR_ORDER   = err_order_q;
    assign o_ERR_TIMEOUT = err_timeout_q;
    assign o_FIFO_COUNT  = count;

endmodule

// File: tb/tb_oled_mode_scheduler.sv
// Directed bench for oled_mode_scheduler; the interface side is played by the
// tasks here, driving i_OLED_READY around each START.
module tb_oled_mode_scheduler;

    localparam int FIFO_DEPTH   = 4;
    localparam int ACK_TIMEOUT  = 200;
    localparam int DONE_TIMEOUT = 500;

    logic       i_CLK = 1'b0;
    logic       i_RST;
    logic       i_REQ_VALID;
    logic [1:0] i_REQ_MODE;
    logic       o_REQ_READY;
    logic       i_ERR_CLR;
    logic       i_OLED_READY;
    logic [1:0] o_MODE;
    logic       o_START;
    logic       o_BUSY;
    logic       o_DISPLAY_ON;
    logic       o_ERR_ORDER;
    logic       o_ERR_TIMEOUT;
    logic [2:0] o_FIFO_COUNT;

    int total = 0;
    int bad   = 0;

    always #5 i_CLK = ~i_CLK;

    oled_mode_scheduler #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_REQ_VALID  (i_REQ_VALID),
        .i_REQ_MODE   (i_REQ_MODE),
        .o_REQ_READY  (o_REQ_READY),
        .i_ERR_CLR    (i_ERR_CLR),
        .i_OLED_READY (i_OLED_READY),
        .o_MODE       (o_MODE),
        .o_START      (o_START),
        .o_BUSY       (o_BUSY),
        .o_DISPLAY_ON (o_DISPLAY_ON),
        .o_ERR_ORDER  (o_ERR_ORDER),
        .o_ERR_TIMEOUT(o_ERR_TIMEOUT),
        .o_FIFO_COUNT (o_FIFO_COUNT)
    );

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic push(input logic [1:0] m);
        i_REQ_VALID = 1'b1;
        i_REQ_MODE  = m;
        step();
        i_REQ_VALID = 1'b0;
    endtask

    task automatic do_reset();
        i_RST = 1'b1;
        step();
        step();
        i_RST = 1'b0;
        repeat (4) step();
    endtask

    // Interface stand-in for one request: ack after ack_dly, ready back after done_dly.
    task automatic serve(input logic [1:0] exp_mode, input int ack_dly, input int done_dly);
        int g;
        g = 0;
        while (o_START !== 1'b1 && g < 40) begin
            step();
            g++;
        end
        total++;
        if (o_START !== 1'b1) begin
            bad++;
            $display("FAIL serve_start: START=%b, want 1", o_START);
            return;
        end
        total++;
        if (o_MODE !== exp_mode) begin
            bad++;
            $display("FAIL serve_mode: got %b want %b", o_MODE, exp_mode);
        end
        repeat (ack_dly) step();
        i_OLED_READY = 1'b0;
        g = 0;
        while (o_START !== 1'b0 && g < 10) begin
            step();
            g++;
        end
        total++;
        if (o_START !== 1'b0) begin
            bad++;
            $display("FAIL serve_start_fall: START=%b, want 0", o_START);
        end
        repeat (done_dly) step();
        i_OLED_READY = 1'b1;
    endtask

    task automatic test_reset();
        i_REQ_VALID  = 1'b1;
        i_REQ_MODE   = 2'b11;
        i_ERR_CLR    = 1'b0;
        i_OLED_READY = 1'b1;
        i_RST        = 1'b1;
        step();
        step();
        total++;
        if (o_START !== 1'b0 || o_MODE !== 2'b00) begin
            bad++;
            $display("FAIL reset_start_mode: start=%b mode=%b want 0/00", o_START, o_MODE);
        end
        total++;
        if (o_BUSY !== 1'b0 || o_DISPLAY_ON !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_disp: busy=%b disp=%b want 0/0", o_BUSY, o_DISPLAY_ON);
        end
        total++;
        if (o_ERR_ORDER !== 1'b0 || o_ERR_TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL reset_errs: order=%b timeout=%b want 0/0", o_ERR_ORDER, o_ERR_TIMEOUT);
        end
        total++;
        if (o_FIFO_COUNT !== 3'd0 || o_REQ_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_fifo: count=%0d ready=%b want 0/1", o_FIFO_COUNT, o_REQ_READY);
        end
        i_REQ_VALID = 1'b0;
        i_RST       = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_turnon();
        logic dropped;
        int   g;
        i_OLED_READY = 1'b1;
        do_reset();
        push(2'b00);
        total++;
        if (o_START !== 1'b0) begin
            bad++;
            $display("FAIL turnon_lat1: START=%b want 0", o_START);
        end
        step();
        total++;
        if (o_START !== 1'b0) begin
            bad++;
            $display("FAIL turnon_lat2: START=%b want 0", o_START);
        end
        step();
        total++;
        if (o_START !== 1'b1 || o_MODE !== 2'b00) begin
            bad++;
            $display("FAIL turnon_lat3: start=%b mode=%b want 1/00", o_START, o_MODE);
        end
        dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_START !== 1'b1) dropped = 1'b1;
        end
        total++;
        if (dropped !== 1'b0) begin
            bad++;
            $display("FAIL turnon_hold: START dropped before ack, want held 1");
        end
        i_OLED_READY = 1'b0;
        g = 0;
        while (o_START !== 1'b0 && g < 10) begin
            step();
            g++;
        end
        total++;
        if (o_START !== 1'b0) begin
            bad++;
            $display("FAIL turnon_ack: START=%b want 0", o_START);
        end
        // Kept under the bench DONE timeout of 500 cycles.
        repeat (400) step();
        total++;
        if (o_DISPLAY_ON !== 1'b0 || o_BUSY !== 1'b1) begin
            bad++;
            $display("FAIL turnon_in_done: disp=%b busy=%b want 0/1", o_DISPLAY_ON, o_BUSY);
        end
        i_OLED_READY = 1'b1;
        g = 0;
        while (o_DISPLAY_ON !== 1'b1 && g < 10) begin
            step();
            g++;
        end
        total++;
        if (o_DISPLAY_ON !== 1'b1 || o_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL turnon_done: disp=%b busy=%b want 1/0", o_DISPLAY_ON, o_BUSY);
        end
    endtask

    task automatic test_order_err();
        logic seen_start;
        i_OLED_READY = 1'b1;
        do_reset();
        push(2'b01);
        seen_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (o_START === 1'b1) seen_start = 1'b1;
            step();
        end
        total++;
        if (seen_start !== 1'b0 || o_ERR_ORDER !== 1'b1) begin
            bad++;
            $display("FAIL order_err: start_seen=%b err=%b want 0/1", seen_start, o_ERR_ORDER);
        end
        total++;
        if (o_FIFO_COUNT !== 3'd0 || o_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL order_drop: count=%0d busy=%b want 0/0", o_FIFO_COUNT, o_BUSY);
        end
        i_ERR_CLR = 1'b1;
        step();
        i_ERR_CLR = 1'b0;
        total++;
        if (o_ERR_ORDER !== 1'b0) begin
            bad++;
            $display("FAIL order_clr: err=%b want 0", o_ERR_ORDER);
        end
    endtask

    task automatic test_fifo_full();
        logic seen_start;
        int   g;
        i_OLED_READY = 1'b0;
        do_reset();
        push(2'b00);
        push(2'b01);
        push(2'b01);
        total++;
        if (o_FIFO_COUNT !== 3'd3 || o_REQ_READY !== 1'b1) begin
            bad++;
            $display("FAIL fifo_three: count=%0d ready=%b want 3/1", o_FIFO_COUNT, o_REQ_READY);
        end
        push(2'b01);
        total++;
        if (o_FIFO_COUNT !== 3'd4 || o_REQ_READY !== 1'b0) begin
            bad++;
            $display("FAIL fifo_four: count=%0d ready=%b want 4/0", o_FIFO_COUNT, o_REQ_READY);
        end
        push(2'b10);
        total++;
        if (o_FIFO_COUNT !== 3'd4 || o_REQ_READY !== 1'b0) begin
            bad++;
            $display("FAIL fifo_overflow: count=%0d ready=%b want 4/0", o_FIFO_COUNT, o_REQ_READY);
        end
        i_OLED_READY = 1'b1;
        serve(2'b00, 5, 20);
        serve(2'b01, 5, 20);
        serve(2'b01, 5, 20);
        serve(2'b01, 5, 20);
        g = 0;
        while (o_BUSY !== 1'b0 && g < 20) begin
            step();
            g++;
        end
        total++;
        if (o_FIFO_COUNT !== 3'd0 || o_BUSY !== 1'b0 || o_DISPLAY_ON !== 1'b1) begin
            bad++;
            $display("FAIL fifo_drain: count=%0d busy=%b disp=%b want 0/0/1",
                     o_FIFO_COUNT, o_BUSY, o_DISPLAY_ON);
        end
        seen_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_START === 1'b1) seen_start = 1'b1;
        end
        total++;
        if (seen_start !== 1'b0) begin
            bad++;
            $display("FAIL fifo_fifth_ignored: extra START seen, want none");
        end
    endtask

    task automatic test_ack_timeout();
        int g;
        int n;
        push(2'b01);
        push(2'b10);
        g = 0;
        while (o_START !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        n = 0;
        while (o_START === 1'b1 && n < 400) begin
            n++;
            step();
        end
        total++;
        if (n != ACK_TIMEOUT) begin
            bad++;
            $display("FAIL ack_hold: START high %0d cycles want %0d", n, ACK_TIMEOUT);
        end
        total++;
        if (o_ERR_TIMEOUT !== 1'b1) begin
            bad++;
            $display("FAIL ack_err: err=%b want 1", o_ERR_TIMEOUT);
        end
        serve(2'b10, 5, 20);
        g = 0;
        while (o_BUSY !== 1'b0 && g < 20) begin
            step();
            g++;
        end
        total++;
        if (o_BUSY !== 1'b0 || o_ERR_TIMEOUT !== 1'b1 || o_DISPLAY_ON !== 1'b1) begin
            bad++;
            $display("FAIL ack_next: busy=%b err=%b disp=%b want 0/1/1",
                     o_BUSY, o_ERR_TIMEOUT, o_DISPLAY_ON);
        end
    endtask

    task automatic test_done_timeout();
        int g;
        i_ERR_CLR = 1'b1;
        step();
        i_ERR_CLR = 1'b0;
        total++;
        if (o_ERR_TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL done_pre_clr: err=%b want 0", o_ERR_TIMEOUT);
        end
        push(2'b00);
        g = 0;
        while (o_START !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        i_OLED_READY = 1'b0;
        g = 0;
        while (o_START !== 1'b0 && g < 10) begin
            step();
            g++;
        end
        repeat (DONE_TIMEOUT - 1) step();
        total++;
        if (o_ERR_TIMEOUT !== 1'b0 || o_DISPLAY_ON !== 1'b1) begin
            bad++;
            $display("FAIL done_early: err=%b disp=%b want 0/1", o_ERR_TIMEOUT, o_DISPLAY_ON);
        end
        // Clear lands on the same edge as the timeout event; the event must win.
        i_ERR_CLR = 1'b1;
        step();
        i_ERR_CLR = 1'b0;
        total++;
        if (o_ERR_TIMEOUT !== 1'b1 || o_DISPLAY_ON !== 1'b0 || o_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL done_timeout: err=%b disp=%b busy=%b want 1/0/0",
                     o_ERR_TIMEOUT, o_DISPLAY_ON, o_BUSY);
        end
    endtask

    task automatic test_reset_mid_issue();
        logic seen_start;
        i_OLED_READY = 1'b1;
        repeat (5) step();
        push(2'b00);
        push(2'b01);
        push(2'b01);
        total++;
        if (o_START !== 1'b1 || o_FIFO_COUNT !== 3'd2) begin
            bad++;
            $display("FAIL midrst_pre: start=%b count=%0d want 1/2", o_START, o_FIFO_COUNT);
        end
        i_RST = 1'b1;
        step();
        total++;
        if (o_START !== 1'b0 || o_FIFO_COUNT !== 3'd0 || o_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL midrst_post: start=%b count=%0d busy=%b want 0/0/0",
                     o_START, o_FIFO_COUNT, o_BUSY);
        end
        i_RST = 1'b0;
        seen_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (o_START === 1'b1) seen_start = 1'b1;
        end
        total++;
        if (seen_start !== 1'b0 || o_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet: start_seen=%b busy=%b want 0/0", seen_start, o_BUSY);
        end
    endtask

    initial begin
        i_RST        = 1'b1;
        i_REQ_VALID  = 1'b0;
        i_REQ_MODE   = 2'b00;
        i_ERR_CLR    = 1'b0;
        i_OLED_READY = 1'b1;
        test_reset();
        test_turnon();
        test_order_err();
        test_fifo_full();
        test_ack_timeout();
        test_done_timeout();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
